// File: rtl/hms_cntdw_pkg.sv
// hms_cntdw_pkg: shared constants for the H:M:S countdown controller.
// State encoding, digit width, default wrap values, preset clamp helper.
package hms_cntdw_pkg;

  localparam int HMS_W      = 6;
  localparam int SEC_MAX_D  = 59;
  localparam int MIN_MAX_D  = 59;
  localparam int HOUR_MAX_D = 23;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  function automatic logic [HMS_W-1:0] clamp(
    input logic [HMS_W-1:0] v,
    input logic [HMS_W-1:0] mx
  );
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/hms_alarm_tmr.sv
// hms_alarm_tmr: tick-counting alarm down-timer.
// Ports: clk, rst_n (sync, active-high), i_start, i_clear, i_tick, o_done.
module hms_alarm_tmr #(
  parameter int TICKS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_done
);

  localparam int CW = $clog2(TICKS + 1);

  logic [CW-1:0] r_cnt;
  logic          r_act;

  // Done fires combinationally on the tick that exhausts the count.
  assign o_done = r_act & i_tick & (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst_n || i_clear) begin
      r_cnt <= '0;
      r_act <= 1'b0;
    end else if (i_start) begin
      r_cnt <= CW'(TICKS);
      r_act <= 1'b1;
    end else if (r_act && i_tick) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1))
        r_act <= 1'b0;
    end
  end

endmodule

// File: rtl/hms_cntdw_ctrl.sv
// hms_cntdw_ctrl: countdown FSM, borrow chain and preset store for H:M:S.
// Ports: pulses i_tick/i_start_stop/i_clear/i_load, level i_alarm_on,
// presets i_pre_*, counts i_*; registered o_load/o_ld_*, o_dec_*,
// o_running, o_alarm, o_state. HMS_CNTDW_REPEAT_EN selects circle mode.
module hms_cntdw_ctrl
  import hms_cntdw_pkg::*;
#(
  parameter int ALARM_TICKS = 10,
  parameter int SEC_MAX     = SEC_MAX_D,
  parameter int MIN_MAX     = MIN_MAX_D,
  parameter int HOUR_MAX    = HOUR_MAX_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic             i_start_stop,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_alarm_on,
  input  logic [HMS_W-1:0] i_pre_hour,
  input  logic [HMS_W-1:0] i_pre_min,
  input  logic [HMS_W-1:0] i_pre_sec,
  input  logic [HMS_W-1:0] i_hour,
  input  logic [HMS_W-1:0] i_min,
  input  logic [HMS_W-1:0] i_sec,
  output logic             o_load,
  output logic [HMS_W-1:0] o_ld_hour,
  output logic [HMS_W-1:0] o_ld_min,
  output logic [HMS_W-1:0] o_ld_sec,
  output logic             o_dec_sec,
  output logic             o_dec_min,
  output logic             o_dec_hour,
  output logic             o_running,
  output logic             o_alarm,
  output logic [1:0]       o_state
);

  localparam logic [HMS_W-1:0] L_SMAX = HMS_W'(SEC_MAX);
  localparam logic [HMS_W-1:0] L_MMAX = HMS_W'(MIN_MAX);
  localparam logic [HMS_W-1:0] L_HMAX = HMS_W'(HOUR_MAX);

  state_t           r_state;
  logic             r_running;
  logic             r_alarm;
  logic             r_load;
  logic             r_ds;
  logic             r_dm;
  logic             r_dh;
  logic [HMS_W-1:0] r_pre_h;
  logic [HMS_W-1:0] r_pre_m;
  logic [HMS_W-1:0] r_pre_s;

  state_t w_nxt;
  logic   w_zero;
  logic   w_cap;
  logic   w_ld;
  logic   w_ds;
  logic   w_dm;
  logic   w_dh;
  logic   w_alm_p;
  logic   w_t_start;
  logic   w_t_clr;
  logic   w_t_done;

  assign w_zero = (i_hour == '0) && (i_min == '0) && (i_sec == '0);

  hms_alarm_tmr #(
    .TICKS (ALARM_TICKS)
  ) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_t_start),
    .i_clear (w_t_clr),
    .i_tick  (i_tick && (r_state == ST_ALARM)),
    .o_done  (w_t_done)
  );

  always_comb begin
    w_nxt     = r_state;
    w_cap     = 1'b0;
    w_ld      = 1'b0;
    w_ds      = 1'b0;
    w_dm      = 1'b0;
    w_dh      = 1'b0;
    w_alm_p   = 1'b0;
    w_t_start = 1'b0;
    w_t_clr   = 1'b0;
    if (i_clear) begin
      w_nxt   = ST_IDLE;
      w_ld    = 1'b1;
      w_t_clr = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            w_cap = 1'b1;
            w_ld  = 1'b1;
          end else if (i_start_stop && !w_zero) begin
            w_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_zero) begin
`ifdef HMS_CNTDW_REPEAT_EN
            // r_load high means the reload is still in flight.
            if (!r_load) begin
              if (r_pre_h == '0 && r_pre_m == '0 && r_pre_s == '0) begin
                w_nxt = ST_IDLE;
              end else begin
                w_ld    = 1'b1;
                w_alm_p = i_alarm_on;
              end
            end
`else
            w_nxt     = i_alarm_on ? ST_ALARM : ST_IDLE;
            w_t_start = i_alarm_on;
`endif
          end else if (i_start_stop) begin
            w_nxt = ST_PAUSE;
          end else if (i_tick) begin
            w_ds = 1'b1;
            w_dm = (i_sec == '0);
            w_dh = (i_sec == '0) && (i_min == '0);
          end
        end
        ST_PAUSE: begin
          if (i_load) begin
            w_cap = 1'b1;
            w_ld  = 1'b1;
          end else if (i_start_stop) begin
            w_nxt = ST_RUN;
          end
        end
        ST_ALARM: begin
          if (i_start_stop || !i_alarm_on || w_t_done) begin
            w_nxt   = ST_IDLE;
            w_t_clr = 1'b1;
          end
        end
        default: w_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
      r_load    <= 1'b0;
      r_ds      <= 1'b0;
      r_dm      <= 1'b0;
      r_dh      <= 1'b0;
      r_pre_h   <= '0;
      r_pre_m   <= '0;
      r_pre_s   <= '0;
    end else begin
      r_state   <= w_nxt;
      r_running <= (w_nxt == ST_RUN);
      r_alarm   <= (w_nxt == ST_ALARM) || w_alm_p;
      r_load    <= w_ld;
      r_ds      <= w_ds;
      r_dm      <= w_dm;
      r_dh      <= w_dh;
      if (w_cap) begin
        r_pre_h <= clamp(i_pre_hour, L_HMAX);
        r_pre_m <= clamp(i_pre_min, L_MMAX);
        r_pre_s <= clamp(i_pre_sec, L_SMAX);
      end
    end
  end

  assign o_state    = r_state;
  assign o_running  = r_running;
  assign o_alarm    = r_alarm;
  assign o_load     = r_load;
  assign o_ld_hour  = r_pre_h;
  assign o_ld_min   = r_pre_m;
  assign o_ld_sec   = r_pre_s;
  assign o_dec_sec  = r_ds;
  assign o_dec_min  = r_dm;
  assign o_dec_hour = r_dh;

endmodule

// File: tb/tb_hms_cntdw_ctrl.sv
// tb_hms_cntdw_ctrl: directed + random bench for hms_cntdw_ctrl.
// Counter datapath and a behavioural controller model live here.
module tb_hms_cntdw_ctrl;

  localparam int AT = 10;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_ALARM = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_tick, i_start_stop, i_clear, i_load, i_alarm_on;
  logic [5:0] i_pre_hour, i_pre_min, i_pre_sec;
  logic       o_load;
  logic [5:0] o_ld_hour, o_ld_min, o_ld_sec;
  logic       o_dec_sec, o_dec_min, o_dec_hour;
  logic       o_running, o_alarm;
  logic [1:0] o_state;

  logic [5:0] dp_h = 6'd0;
  logic [5:0] dp_m = 6'd0;
  logic [5:0] dp_s = 6'd0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int m_st, m_ph, m_pm, m_ps, m_acnt;
  bit m_ld;
  int e_st;
  bit e_ld, e_ds, e_dm, e_dh, e_alm;

  always #5 clk = ~clk;

  hms_cntdw_ctrl #(.ALARM_TICKS(AT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tick       (i_tick),
    .i_start_stop (i_start_stop),
    .i_clear      (i_clear),
    .i_load       (i_load),
    .i_alarm_on   (i_alarm_on),
    .i_pre_hour   (i_pre_hour),
    .i_pre_min    (i_pre_min),
    .i_pre_sec    (i_pre_sec),
    .i_hour       (dp_h),
    .i_min        (dp_m),
    .i_sec        (dp_s),
    .o_load       (o_load),
    .o_ld_hour    (o_ld_hour),
    .o_ld_min     (o_ld_min),
    .o_ld_sec     (o_ld_sec),
    .o_dec_sec    (o_dec_sec),
    .o_dec_min    (o_dec_min),
    .o_dec_hour   (o_dec_hour),
    .o_running    (o_running),
    .o_alarm      (o_alarm),
    .o_state      (o_state)
  );

  // Counter datapath: load wins, decrement from 0 wraps to max.
  always @(posedge clk) begin
    if (o_load) begin
      dp_h <= o_ld_hour;
      dp_m <= o_ld_min;
      dp_s <= o_ld_sec;
    end else begin
      if (o_dec_sec)  dp_s <= (dp_s == 0) ? 6'd59 : dp_s - 6'd1;
      if (o_dec_min)  dp_m <= (dp_m == 0) ? 6'd59 : dp_m - 6'd1;
      if (o_dec_hour) dp_h <= (dp_h == 0) ? 6'd23 : dp_h - 6'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
             tag, cyc, obs, exp);
    end
  endtask

  function automatic int cl(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_ph = 0; m_pm = 0; m_ps = 0;
    m_acnt = 0; m_ld = 0;
  endtask

  // Reference: next registered outputs from current inputs and counts.
  task automatic model();
    int t, nt;
    t = dp_h * 3600 + dp_m * 60 + dp_s;
    e_st = m_st; e_ld = 0; e_ds = 0; e_dm = 0; e_dh = 0; e_alm = 0;
    if (i_clear) begin
      e_st = S_IDLE; e_ld = 1; m_acnt = 0;
    end else if (m_st == S_IDLE || m_st == S_PAUSE) begin
      if (i_load) begin
        m_ph = cl(i_pre_hour, 23);
        m_pm = cl(i_pre_min, 59);
        m_ps = cl(i_pre_sec, 59);
        e_ld = 1;
      end else if (i_start_stop && (m_st == S_PAUSE || t != 0)) begin
        e_st = S_RUN;
      end
    end else if (m_st == S_RUN) begin
      if (t == 0) begin
`ifdef HMS_CNTDW_REPEAT_EN
        if (!m_ld) begin
          if (m_ph + m_pm + m_ps == 0) e_st = S_IDLE;
          else begin e_ld = 1; e_alm = i_alarm_on; end
        end
`else
        e_st = i_alarm_on ? S_ALARM : S_IDLE;
        m_acnt = 0;
`endif
      end else if (i_start_stop) begin
        e_st = S_PAUSE;
      end else if (i_tick) begin
        nt = t - 1;
        e_ds = 1;
        e_dm = ((nt / 60) % 60) != dp_m;
        e_dh = (nt / 3600) != dp_h;
      end
    end else begin
      if (i_start_stop || !i_alarm_on) begin
        e_st = S_IDLE; m_acnt = 0;
      end else if (i_tick) begin
        m_acnt++;
        if (m_acnt == AT) begin e_st = S_IDLE; m_acnt = 0; end
      end
    end
    m_st = e_st;
    m_ld = e_ld;
  endtask

  task automatic step(input bit tk, input bit ss, input bit cr,
                      input bit ld);
    i_tick = tk; i_start_stop = ss; i_clear = cr; i_load = ld;
    model();
    @(posedge clk); #1;
    cyc++;
    chk("state",   o_state,    e_st);
    chk("running", o_running,  e_st == S_RUN);
    chk("alarm",   o_alarm,    (e_st == S_ALARM) || e_alm);
    chk("load",    o_load,     e_ld);
    chk("ld_h",    o_ld_hour,  m_ph);
    chk("ld_m",    o_ld_min,   m_pm);
    chk("ld_s",    o_ld_sec,   m_ps);
    chk("dec_s",   o_dec_sec,  e_ds);
    chk("dec_m",   o_dec_min,  e_dm);
    chk("dec_h",   o_dec_hour, e_dh);
    i_tick = 0; i_start_stop = 0; i_clear = 0; i_load = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  task automatic preset(input int h, input int m, input int s);
    i_pre_hour = 6'(h); i_pre_min = 6'(m); i_pre_sec = 6'(s);
  endtask

  initial begin
    rst_n = 1; i_tick = 0; i_start_stop = 0; i_clear = 0; i_load = 0;
    i_alarm_on = 0;
    preset(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", o_state, 0);
    chk("rst_load", o_load, 0);
    chk("rst_alarm", o_alarm, 0);
    chk("rst_run", o_running, 0);
    chk("rst_ld", {o_ld_hour, o_ld_min, o_ld_sec}, 0);
    chk("rst_dec", {o_dec_sec, o_dec_min, o_dec_hour}, 0);
    rst_n = 0;
    model_reset();

    // 01:00:00 single tick borrows through all digits
    preset(1, 0, 0); step(0, 0, 0, 1); idle(1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("borrow_all", {o_dec_sec, o_dec_min, o_dec_hour}, 3'b111);
    idle(1);
    chk("dp_after_borrow", {dp_h, dp_m, dp_s}, {6'd0, 6'd59, 6'd59});
    step(0, 0, 1, 0); idle(1);

    // 00:00:02 with alarm
    i_alarm_on = 1;
    preset(0, 0, 2); step(0, 0, 0, 1); idle(1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0); idle(1);
    step(1, 0, 0, 0); idle(1);
    chk("not_yet_alarm", o_state, S_RUN);
    idle(1);
    chk("to_alarm", o_state, S_ALARM);
    for (int k = 0; k < AT - 1; k++) step(1, 0, 0, 0);
    chk("alarm_hold", o_alarm, 1);
    step(1, 0, 0, 0);
    chk("alarm_end_state", o_state, S_IDLE);
    chk("alarm_end_out", o_alarm, 0);

    // pause drops ticks, clear restores presets
    preset(0, 0, 5); step(0, 0, 0, 1); idle(1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0); idle(1);
    step(1, 0, 0, 0); idle(1);
    step(0, 1, 0, 0);
    chk("pause", o_state, S_PAUSE);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0);
      chk("pause_nodec", o_dec_sec, 0);
    end
    step(0, 0, 1, 0);
    chk("clr_state", o_state, S_IDLE);
    chk("clr_load", o_load, 1);
    chk("clr_ld_sec", o_ld_sec, 5);
    idle(1);

    // zero counts: start ignored; clamp
    preset(0, 0, 0); step(0, 0, 0, 1); idle(1);
    step(0, 1, 0, 0);
    chk("zero_start", o_state, S_IDLE);
    preset(40, 63, 60); step(0, 0, 0, 1);
    chk("clamp", {o_ld_hour, o_ld_min, o_ld_sec}, {6'd23, 6'd59, 6'd59});
    idle(1);

    // same-cycle cases
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("ss_tick_state", o_state, S_PAUSE);
    chk("ss_tick_dec", o_dec_sec, 0);
    step(0, 0, 1, 0); idle(1);
    step(0, 1, 1, 0);
    chk("clr_ss_state", o_state, S_IDLE);
    chk("clr_ss_load", o_load, 1);
    idle(1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("mid_rst", {o_state, o_running, o_alarm, o_load, o_ld_hour,
                    o_ld_min, o_ld_sec, o_dec_sec, o_dec_min,
                    o_dec_hour}, 0);
    rst_n = 0;
    model_reset();
    idle(1);

`ifdef HMS_CNTDW_REPEAT_EN
    i_alarm_on = 1;
    preset(0, 0, 1); step(0, 0, 0, 1); idle(1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0); idle(2);
    chk("rep_load", o_load, 1);
    chk("rep_ld_sec", o_ld_sec, 1);
    chk("rep_alarm", o_alarm, 1);
    chk("rep_state", o_state, S_RUN);
    idle(1);
    chk("rep_alarm_pulse", o_alarm, 0);
    step(0, 0, 1, 0); idle(1);
`endif

    // randomized phase against the model
    for (int n = 0; n < 4000; n++) begin
      bit tk, ss, cr, ld;
      i_alarm_on = ($urandom_range(0, 19) != 0);
      tk = ($urandom_range(0, 1) == 0);
      ss = ($urandom_range(0, 15) == 0);
      cr = ($urandom_range(0, 79) == 0);
      ld = ($urandom_range(0, 9) == 0);
      if (ld) begin
        preset(($urandom_range(0, 15) == 0) ? $urandom_range(0, 63) : 0,
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63)
                                           : $urandom_range(0, 1),
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63)
                                           : $urandom_range(0, 9));
      end
      step(tk, ss, cr, ld);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hms_cntdw_ctrl.md
Name: hms_cntdw_ctrl

Overview:
Sequencing controller for the H:M:S countdown datapath, which is three decrementing counters (hour, min, sec).
- Turns user pulses (load, start/stop, clear) and alarm on/off into per-digit decrement strobes, preset-load strobes and an alarm output.
- Sits between the button/debounce logic and the counters; owns the countdown FSM and the borrow chain.

Parameters:
ALARM_TICKS, 10, number of i_tick periods o_alarm stays high before auto-return to IDLE (1..255)
SEC_MAX, 59, seconds wrap value; presets above it are clamped to it
MIN_MAX, 59, minutes wrap value; presets above it are clamped to it
HOUR_MAX, 23, hours wrap value; presets above it are clamped to it

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-high (level 1 resets on the clk edge)
i_tick  in  1  one-cycle 1 Hz strobe
i_start_stop  in  1  one-cycle pulse; toggles run/pause
i_clear  in  1  one-cycle pulse; abort and restore presets
i_load  in  1  one-cycle pulse; capture i_pre_*
i_alarm_on  in  1  level; alarm enable
i_pre_hour / i_pre_min / i_pre_sec  in  6 each  preset values
i_hour / i_min / i_sec  in  6 each  current datapath counts
o_load  out  1  one-cycle load strobe to the datapath
o_ld_hour / o_ld_min / o_ld_sec  out  6 each  clamped stored presets
o_dec_sec / o_dec_min / o_dec_hour  out  1 each  one-cycle decrement strobes
o_running  out  1  state==RUN
o_alarm  out  1  state==ALARM
o_state  out  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; stored presets 0; alarm counter 0; every output 0.
- Datapath contract:
  - o_load has priority in the datapath; the datapath loads o_ld_*.
  - A dec strobe on a counter at 0 wraps it to *_MAX.
  - Counts update one cycle after the strobe.
- zero = (i_hour==0 && i_min==0 && i_sec==0), combinational.
- Clamp: each stored preset = min(i_pre_x, X_MAX).
- Priority order, highest first: rst_n > i_clear > i_load > i_start_stop > i_tick.
- i_clear, any state: next state IDLE, o_load=1 for one cycle using the stored presets, alarm counter cleared.
- IDLE:
  - i_load: capture presets; o_load=1 next cycle; stay IDLE.
  - i_start_stop with zero=0: go to RUN.
  - i_start_stop with zero=1: ignored.
  - i_start_stop in the same cycle as i_load: ignored.
- RUN:
  - On i_tick with zero=0, next cycle:
    - o_dec_sec=1.
    - o_dec_min=1 if i_sec==0.
    - o_dec_hour=1 if i_sec==0 && i_min==0.
  - On zero=1 (checked every cycle, so two cycles after the final tick):
    - go to ALARM if i_alarm_on, else IDLE.
    - No strobes are issued while zero=1.
  - i_start_stop: go to PAUSE. A tick in the same cycle is dropped (no strobes).
  - i_load: ignored.
- PAUSE:
  - i_tick: ignored.
  - i_start_stop: go to RUN.
  - i_load: capture presets; o_load=1; stay PAUSE.
- ALARM:
  - Alarm counter increments on each i_tick; go to IDLE when it reaches ALARM_TICKS.
  - i_start_stop, or i_alarm_on low: go to IDLE next cycle.
  - Counter clears on exit.
  - Datapath is not reloaded on exit.
- Strobes are never asserted outside RUN; o_load is never asserted in the same cycle as any dec strobe.

Optional Feature:
Macro: HMS_CNTDW_REPEAT_EN
- Defined: RUN reaching zero=1 does not leave RUN. Instead:
  - o_load=1 with the stored presets.
  - o_alarm pulses high for one cycle if i_alarm_on.
  - Countdown continues (circle mode).
  - If the stored presets are all 0: go to IDLE instead.
- Undefined: behaviour exactly as above; ALARM state used.

Decomposition:
- Package hms_cntdw_pkg holds:
  - state encoding constants (IDLE/RUN/PAUSE/ALARM, 2-bit);
  - SEC_MAX/MIN_MAX/HOUR_MAX defaults;
  - HMS_W=6.
- One sub-module, hms_alarm_tmr: tick-counting down-timer with start, clear and a done output, sized by ALARM_TICKS.
- Clamp and borrow logic stay inline.

Test Plan:
- Load 01:00:00, start, 1 tick (counts 00:00:00 → wrap model): the cycle after the tick has o_dec_sec=o_dec_min=o_dec_hour=1 → datapath 00:59:59.
- Load 00:00:02, i_alarm_on=1, start, 2 ticks → RUN to ALARM 2 cycles after the 2nd tick; o_alarm high for 10 ticks, then IDLE with o_alarm=0.
- Load 00:00:05, start, 2 ticks, start_stop → PAUSE; 3 ticks give no strobes; clear → IDLE, o_load=1, o_ld_sec=5.
- Presets hour=40, min=63, sec=60 with load → o_ld = 23/59/59. Start with all counts zero (no load) → stays IDLE.
- Same-cycle cases:
  - start_stop + tick in RUN → PAUSE, no strobes.
  - clear + start_stop in IDLE → IDLE, o_load=1.
  - rst_n=1 mid-RUN → all outputs 0 next edge.
- With HMS_CNTDW_REPEAT_EN, load 00:00:01, alarm on, start, 1 tick → o_load=1 with o_ld_sec=1, one-cycle o_alarm, state stays RUN.
